galaga_input_ctrl: RTL and testbench

//  Front end that drives the ship and game FSMs: conditions six raw player buttons (left/right/fire x2)
//  and emits tick-aligned LEFT/RIGHT levels plus single-cycle DP1/DP2 shot strobes.

---
 rtl/galaga_input_ctrl_pkg.sv | 28 ++
 rtl/galaga_input_ctrl_btn_debounce.sv | 45 ++++
 rtl/galaga_input_ctrl.sv | 145 ++++++++++++++
 tb/tb_galaga_input_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/galaga_input_ctrl_pkg.sv
// Shared types and defaults for the Galaga input front end.
package galaga_input_ctrl_pkg;

   localparam int unsigned DB_CYCLES_DEF = 4;
   localparam int unsigned TICK_DIV_DEF  = 8;
   localparam int unsigned COOLDOWN_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      FIRE  = 2'b10,
      COOL  = 2'b11
   } shot_state_t;

   typedef enum logic {
      PRIO_P1 = 1'b0,
      PRIO_P2 = 1'b1
   } prio_t;

   // Bit positions of the buttons in the debouncer bank.
   localparam int unsigned IDX_L1 = 0;
   localparam int unsigned IDX_R1 = 1;
   localparam int unsigned IDX_F1 = 2;
   localparam int unsigned IDX_L2 = 3;
   localparam int unsigned IDX_R2 = 4;
   localparam int unsigned IDX_F2 = 5;

endpackage

// File: rtl/galaga_input_ctrl_btn_debounce.sv
// One pushbutton conditioner: 2-FF synchroniser, stability counter and
// rising-edge strobe aligned with the cycle the stable level goes high.
module btn_debounce
   import galaga_input_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         rise   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            // This edge is the DB_CYCLES-th consecutive differing cycle.
            cnt    <= '0;
            stable <= sync2;
            rise   <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/galaga_input_ctrl.sv
// Button front end: debounced direction levels latched on game ticks and
// arbitrated single-cycle shot strobes with per-player cooldown.
module galaga_input_ctrl
   import galaga_input_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
   parameter int unsigned COOLDOWN  = COOLDOWN_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_L1,
   input  logic BTN_R1,
   input  logic BTN_F1,
   input  logic BTN_L2,
   input  logic BTN_R2,
   input  logic BTN_F2,
   output logic TICK,
   output logic LEFT1,
   output logic RIGHT1,
   output logic LEFT2,
   output logic RIGHT2,
   output logic DP1,
   output logic DP2,
   output logic COOL1,
   output logic COOL2
);

   localparam int unsigned TW = $clog2(TICK_DIV + 1);
   localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic [5:0] raw_btn;
   logic [5:0] db_stable;
   logic [5:0] db_rise;
   logic       unused_db;

   assign raw_btn = {BTN_F2, BTN_R2, BTN_L2, BTN_F1, BTN_R1, BTN_L1};

   for (genvar i = 0; i < 6; i++) begin : g_db
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .CLK   (CLK),
         .RST   (RST),
         .raw   (raw_btn[i]),
         .stable(db_stable[i]),
         .rise  (db_rise[i])
      );
   end

   assign unused_db = ^{db_stable[IDX_F1], db_stable[IDX_F2],
                        db_rise[IDX_L1], db_rise[IDX_R1],
                        db_rise[IDX_L2], db_rise[IDX_R2]};

   logic [TW-1:0] tick_cnt;
   logic          tick;

   assign tick = (tick_cnt == TW'(TICK_DIV - 1));
   assign TICK = tick;

   always_ff @(posedge CLK) begin
      if (RST) begin
         tick_cnt <= '0;
         LEFT1    <= 1'b0;
         RIGHT1   <= 1'b0;
         LEFT2    <= 1'b0;
         RIGHT2   <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) begin
            LEFT1  <= db_stable[IDX_L1];
            RIGHT1 <= db_stable[IDX_R1];
            LEFT2  <= db_stable[IDX_L2];
            RIGHT2 <= db_stable[IDX_R2];
         end
      end
   end

   shot_state_t   state     [2];
   shot_state_t   state_nxt [2];
   logic [CW-1:0] cool      [2];
   logic [CW-1:0] cool_nxt  [2];
   logic [1:0]    fire_rise;
   logic [1:0]    grant;
   prio_t         prio;
   prio_t         prio_nxt;

   assign fire_rise = {db_rise[IDX_F2], db_rise[IDX_F1]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         prio <= PRIO_P1;
         for (int unsigned p = 0; p < 2; p++) begin
            state[p] <= IDLE;
            cool[p]  <= '0;
         end
      end else begin
         prio <= prio_nxt;
         for (int unsigned p = 0; p < 2; p++) begin
            state[p] <= state_nxt[p];
            cool[p]  <= cool_nxt[p];
         end
      end
   end

   always_comb begin
      grant[0] = (state[0] == ARMED) && ((state[1] != ARMED) || (prio == PRIO_P1));
      grant[1] = (state[1] == ARMED) && ((state[0] != ARMED) || (prio == PRIO_P2));
      prio_nxt = prio;
      if (tick && (state[0] == ARMED) && (state[1] == ARMED)) begin
         prio_nxt = (prio == PRIO_P1) ? PRIO_P2 : PRIO_P1;
      end
      for (int unsigned p = 0; p < 2; p++) begin
         state_nxt[p] = state[p];
         cool_nxt[p]  = cool[p];
         unique case (state[p])
            IDLE:  if (fire_rise[p]) state_nxt[p] = ARMED;
            ARMED: if (tick && grant[p]) state_nxt[p] = FIRE;
            FIRE: begin
               if (COOLDOWN == 0) begin
                  state_nxt[p] = IDLE;
               end else begin
                  state_nxt[p] = COOL;
                  cool_nxt[p]  = CW'(COOLDOWN);
               end
            end
            COOL: begin
               // Leaving on the tick that would bring the count to zero.
               if (tick) begin
                  if (cool[p] <= CW'(1)) begin
                     state_nxt[p] = IDLE;
                     cool_nxt[p]  = '0;
                  end else begin
                     cool_nxt[p] = cool[p] - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign DP1   = (state[0] == FIRE);
   assign DP2   = (state[1] == FIRE);
   assign COOL1 = (state[0] == COOL);
   assign COOL2 = (state[1] == COOL);

endmodule

// File: tb/tb_galaga_input_ctrl.sv
// Directed bench for galaga_input_ctrl with DB_CYCLES=4, TICK_DIV=8, COOLDOWN=3.
module tb_galaga_input_ctrl;

   logic CLK = 1'b0;
   logic RST;
   logic BTN_L1, BTN_R1, BTN_F1, BTN_L2, BTN_R2, BTN_F2;
   logic TICK, LEFT1, RIGHT1, LEFT2, RIGHT2, DP1, DP2, COOL1, COOL2;

   int total = 0;
   int bad   = 0;
   int t     = 0;

   always #5 CLK = ~CLK;

   galaga_input_ctrl #(.DB_CYCLES(4), .TICK_DIV(8), .COOLDOWN(3)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .BTN_L1(BTN_L1),
      .BTN_R1(BTN_R1),
      .BTN_F1(BTN_F1),
      .BTN_L2(BTN_L2),
      .BTN_R2(BTN_R2),
      .BTN_F2(BTN_F2),
      .TICK  (TICK),
      .LEFT1 (LEFT1),
      .RIGHT1(RIGHT1),
      .LEFT2 (LEFT2),
      .RIGHT2(RIGHT2),
      .DP1   (DP1),
      .DP2   (DP2),
      .COOL1 (COOL1),
      .COOL2 (COOL2)
   );

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s t=%0d got=%b exp=%b", tag, t, obs, exp_v);
      end
   endtask

   // t counts falling edges since reset release; TICK is high when t%8 == 7.
   task automatic cyc();
      @(negedge CLK);
      t++;
      chk("tick", TICK, (t % 8) == 7);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tick"},   TICK,   1'b0);
      chk({tag, "_left1"},  LEFT1,  1'b0);
      chk({tag, "_right1"}, RIGHT1, 1'b0);
      chk({tag, "_left2"},  LEFT2,  1'b0);
      chk({tag, "_right2"}, RIGHT2, 1'b0);
      chk({tag, "_dp1"},    DP1,    1'b0);
      chk({tag, "_dp2"},    DP2,    1'b0);
      chk({tag, "_cool1"},  COOL1,  1'b0);
      chk({tag, "_cool2"},  COOL2,  1'b0);
   endtask

   initial begin
      {BTN_L1, BTN_R1, BTN_F1, BTN_L2, BTN_R2, BTN_F2} = '0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      t   = 0;
      chk_all_zero("reset");

      // Tick cadence from release.
      while (t < 15) begin
         cyc();
         chk("idle_dp1", DP1, 1'b0);
         chk("idle_left1", LEFT1, 1'b0);
      end

      // Bouncing left, hold, release; then both P2 directions together.
      while (t < 56) begin
         if (t >= 15 && t < 27) BTN_L1 = ((t - 15) % 4) < 2;
         if (t == 27) BTN_L1 = 1'b1;
         if (t == 40) begin
            BTN_L1 = 1'b0;
            BTN_L2 = 1'b1;
            BTN_R2 = 1'b1;
         end
         if (t == 48) begin
            BTN_L2 = 1'b0;
            BTN_R2 = 1'b0;
         end
         cyc();
         chk("left1",  LEFT1,  (t >= 40) && (t < 48));
         chk("right1", RIGHT1, 1'b0);
         chk("left2",  LEFT2,  (t >= 48) && (t < 56));
         chk("right2", RIGHT2, (t >= 48) && (t < 56));
      end

      // Held fire gives one shot; re-press during cooldown dropped; later re-press fires.
      while (t < 176) begin
         if (t == 56)  BTN_F1 = 1'b1;
         if (t == 96)  BTN_F1 = 1'b0;
         if (t == 104) BTN_F1 = 1'b1;
         if (t == 112) BTN_F1 = 1'b0;
         if (t == 120) BTN_F1 = 1'b1;
         if (t == 128) BTN_F1 = 1'b0;
         if (t == 138) BTN_F1 = 1'b1;
         if (t == 152) BTN_F1 = 1'b0;
         cyc();
         chk("p1_dp1", DP1, (t == 64) || (t == 112) || (t == 152));
         chk("p1_cool1", COOL1, ((t >= 65) && (t <= 87)) || ((t >= 113) && (t <= 135))
                                || ((t >= 153) && (t <= 175)));
         chk("p1_dp2", DP2, 1'b0);
         chk("p1_cool2", COOL2, 1'b0);
      end

      // Simultaneous presses landing on a tick: arm only, then alternate priority.
      while (t < 272) begin
         if (t == 177) begin BTN_F1 = 1'b1; BTN_F2 = 1'b1; end
         if (t == 192) begin BTN_F1 = 1'b0; BTN_F2 = 1'b0; end
         if (t == 225) begin BTN_F1 = 1'b1; BTN_F2 = 1'b1; end
         if (t == 240) begin BTN_F1 = 1'b0; BTN_F2 = 1'b0; end
         cyc();
         chk("arb_dp1", DP1, (t == 192) || (t == 248));
         chk("arb_dp2", DP2, (t == 200) || (t == 240));
         chk("arb_cool1", COOL1, ((t >= 193) && (t <= 215)) || ((t >= 249) && (t <= 271)));
         chk("arb_cool2", COOL2, ((t >= 201) && (t <= 223)) || ((t >= 241) && (t <= 263)));
      end

      // Arm P1, then reset one cycle before the tick that would grant it.
      while (t < 286) begin
         if (t == 273) BTN_F1 = 1'b1;
         if (t == 281) BTN_F1 = 1'b0;
         cyc();
         chk("pre_rst_dp1", DP1, 1'b0);
         chk("pre_rst_cool1", COOL1, 1'b0);
      end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      t   = 0;
      chk_all_zero("mid_rst");
      while (t < 40) begin
         cyc();
         chk("post_rst_dp1", DP1, 1'b0);
         chk("post_rst_cool1", COOL1, 1'b0);
         chk("post_rst_dp2", DP2, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
